arbiter_rr_n: RTL and testbench

N-requester round-robin arbiter with registered one-hot grant, bounded grant hold and a runtime fixed-priority mode. It generalises the team's two-requester arbiter to a parametrised channel count. It sits between N bus masters and a shared resource, and is the single point of grant decisions for that resource.

---
 rtl/arbiter_rr_n.sv | 139 +++++++++++++
 tb/tb_arbiter_rr_n.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr_n.sv
// arbiter_rr_n: N-requester round-robin / fixed-priority arbiter with
// registered one-hot grant and bounded grant hold.
module arbiter_rr_n #(
  parameter  int unsigned N        = 4,
  parameter  int unsigned MAX_HOLD = 4,
  localparam int unsigned IDW      = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           mode_fixed,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  localparam int unsigned HCW       = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  logic [IDW-1:0] ptr;
  logic [HCW-1:0] hcnt;

  logic [N-1:0]   arb_vec;
  logic           do_arb;
  logic           keep;
  logic           regrant;
  logic           hold_req;
  logic [N-1:0]   others;
  logic           at_limit;

  logic           win_found;
  logic [IDW-1:0] win_id;
  int             idx;

  logic [N-1:0]   gnt_n;
  logic           gnt_valid_n;
  logic [IDW-1:0] gnt_id_n;
  logic [IDW-1:0] ptr_n;
  logic [HCW-1:0] hcnt_n;

  // Rotation pointer successor, wrapping N-1 back to 0.
  function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] x);
    return (x == IDW'(N - 1)) ? '0 : x + IDW'(1);
  endfunction

  // Decide what this edge does: arbitrate, keep the holder, or re-grant it.
  always_comb begin
    arb_vec  = '0;
    do_arb   = 1'b0;
    keep     = 1'b0;
    regrant  = 1'b0;
    hold_req = |(req & gnt);
    others   = req & ~gnt;
    at_limit = (MAX_HOLD != 0) && (hcnt == HCW'(HOLD_LAST));
    if (!gnt_valid) begin
      arb_vec = req;
      do_arb  = 1'b1;
    end else if (!hold_req) begin
      arb_vec = others;
      do_arb  = 1'b1;
    end else if (!at_limit) begin
      keep = 1'b1;
    end else if (|others) begin
      arb_vec = others;
      do_arb  = 1'b1;
    end else begin
      regrant = 1'b1;
    end
  end

  // Pick the winner from arb_vec; downward scans leave the best candidate last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    if (mode_fixed) begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (arb_vec[i]) begin
          win_found = 1'b1;
          win_id    = IDW'(i);
        end
      end
    end else begin
      for (int k = int'(N) - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= int'(N)) idx = idx - int'(N);
        if (arb_vec[idx]) begin
          win_found = 1'b1;
          win_id    = IDW'(idx);
        end
      end
    end
  end

  // Next grant, pointer and hold-count values.
  always_comb begin
    gnt_n       = gnt;
    gnt_valid_n = gnt_valid;
    gnt_id_n    = gnt_id;
    ptr_n       = ptr;
    hcnt_n      = hcnt;
    if (do_arb) begin
      hcnt_n = '0;
      if (win_found) begin
        gnt_n       = {{(N-1){1'b0}}, 1'b1} << win_id;
        gnt_valid_n = 1'b1;
        gnt_id_n    = win_id;
        if (!mode_fixed) ptr_n = ptr_after(win_id);
      end else begin
        gnt_n       = '0;
        gnt_valid_n = 1'b0;
        gnt_id_n    = '0;
      end
    end else if (keep) begin
      if (MAX_HOLD != 0) hcnt_n = hcnt + HCW'(1);
    end else if (regrant) begin
      hcnt_n = '0;
      if (!mode_fixed) ptr_n = ptr_after(gnt_id);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= '0;
      hcnt      <= '0;
    end else begin
      gnt       <= gnt_n;
      gnt_valid <= gnt_valid_n;
      gnt_id    <= gnt_id_n;
      ptr       <= ptr_n;
      hcnt      <= hcnt_n;
    end
  end

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Scoreboard bench for arbiter_rr_n: driver pushes model predictions,
// monitor pops and compares one per clock.
module tb_arbiter_rr_n;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned IDW      = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req = '0;
  logic           mode_fixed = 1'b0;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;

  typedef struct packed {
    logic [N-1:0]   g;
    logic           v;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: holder index (-1 idle), pointer, cycles held.
  int m_holder = -1;
  int m_ptr    = 0;
  int m_hcnt   = 0;

  arbiter_rr_n #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode_fixed(mode_fixed),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] c, input logic mf);
    if (mf) begin
      for (int i = 0; i < int'(N); i++) if (c[i]) return i;
    end else begin
      for (int k = 0; k < int'(N); k++) if (c[(m_ptr + k) % int'(N)]) return (m_ptr + k) % int'(N);
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_holder = -1;
    m_ptr    = 0;
    m_hcnt   = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic mf);
    logic [N-1:0] cand;
    logic [N-1:0] rest;
    int w;
    cand = r;
    if (m_holder >= 0) begin
      rest = r;
      rest[m_holder] = 1'b0;
      if (!r[m_holder]) begin
        cand = rest;
      end else if (MAX_HOLD == 0 || m_hcnt < int'(MAX_HOLD) - 1) begin
        m_hcnt++;
        return;
      end else if (rest != '0) begin
        cand = rest;
      end else begin
        m_hcnt = 0;
        if (!mf) m_ptr = (m_holder + 1) % int'(N);
        return;
      end
    end
    w = pick(cand, mf);
    m_hcnt = 0;
    if (w < 0) begin
      m_holder = -1;
    end else begin
      m_holder = w;
      if (!mf) m_ptr = (w + 1) % int'(N);
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.g  = (m_holder < 0) ? '0 : (N'(1) << m_holder);
    e.v  = (m_holder >= 0);
    e.id = (m_holder < 0) ? '0 : IDW'(m_holder);
    return e;
  endfunction

  // Apply one cycle of stimulus at a falling edge and predict the next grant.
  task automatic drive(input logic [N-1:0] r, input logic mf);
    req        = r;
    mode_fixed = mf;
    model_step(r, mf);
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  // Monitor: compare the registered outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("grant", 32'({gnt, gnt_valid, gnt_id}), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] r;
    logic         mf;

    // Reset held with all requests asserted.
    rst_n = 1'b0;
    req   = '1;
    repeat (3) @(negedge clk);
    check("reset_gnt",   32'(gnt),       32'h0);
    check("reset_valid", 32'(gnt_valid), 32'h0);
    check("reset_id",    32'(gnt_id),    32'h0);
    req   = '0;
    rst_n = 1'b1;
    model_reset();
    repeat (3) drive(4'b0000, 1'b0);

    // Round-robin rotation under full load.
    repeat (20) drive(4'b1111, 1'b0);

    // Lone holder keeps the grant across hold-limit re-grants, then drops.
    repeat (10) drive(4'b0100, 1'b0);
    drive(4'b0000, 1'b0);

    // Early release hands off with no idle cycle.
    repeat (2) drive(4'b0011, 1'b0);
    drive(4'b0010, 1'b0);
    drive(4'b0000, 1'b0);

    // Fixed priority: bit 1 wins each fresh arbitration, then hold limit.
    drive(4'b0000, 1'b1);
    repeat (3) begin
      repeat (2) drive(4'b1010, 1'b1);
      drive(4'b0000, 1'b1);
    end
    repeat (8) drive(4'b1010, 1'b1);
    drive(4'b0000, 1'b1);
    // Back to round-robin with the pointer left unchanged.
    repeat (6) drive(4'b1111, 1'b0);

    // Asynchronous reset in the middle of a grant.
    drive(4'b0000, 1'b0);
    repeat (2) drive(4'b0100, 1'b0);
    check("pre_reset_gnt", 32'(gnt), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt",   32'(gnt),       32'h0);
    check("async_valid", 32'(gnt_valid), 32'h0);
    check("async_id",    32'(gnt_id),    32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 1'b0);
    check("post_reset_gnt", 32'(gnt), 32'h1);

    // Randomized traffic with sticky requests and occasional mode flips.
    r  = 4'b1111;
    mf = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < int'(N); b++) if ($urandom_range(3) == 0) r[b] = ~r[b];
      if ($urandom_range(15) == 0) mf = ~mf;
      if ($urandom_range(31) == 0) r = '1;
      drive(r, mf);
    end
    drive(4'b0000, 1'b0);

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
